// File: rtl/camera_pkg.sv
// Shared types and constants for the camera pixel-array sequencer.
// State enum, readout step decode, exposure bounds.
package camera_pkg;

  localparam int EXP_W  = 5;
  localparam int STEP_W = 3;

  localparam logic [STEP_W-1:0] STEP_LAST = 3'd7;

  localparam logic [EXP_W-1:0] EXP_MIN_DEF = 5'd2;
  localparam logic [EXP_W-1:0] EXP_MAX_DEF = 5'd30;
  localparam logic [EXP_W-1:0] EXP_RST_DEF = 5'd15;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXPOSURE = 2'd1,
    READOUT  = 2'd2
  } state_e;

  typedef struct packed {
    logic nre1;
    logic nre2;
    logic adc;
  } rd_t;

  // Steps 0-2 read row 1, 4-6 read row 2, 3 and 7 are gaps.
  // ADC strobes in the middle step of each row.
  function automatic rd_t rd_decode(input logic [STEP_W-1:0] step);
    rd_t  r;
    logic gap;
    gap    = (step[1:0] == 2'd3);
    r.nre1 = step[2] | gap;
    r.nre2 = ~step[2] | gap;
    r.adc  = (step[1:0] == 2'd1);
    return r;
  endfunction

endpackage

// File: rtl/camera_ctrl_exposure_adjust.sv
// Button edge detection and saturating exposure register.
// Ports: Clk, Reset, Enable, Exp_increase, Exp_decrease -> Value[4:0].
module exposure_adjust
  import camera_pkg::*;
#(
  parameter logic [EXP_W-1:0] EXP_MIN = EXP_MIN_DEF,
  parameter logic [EXP_W-1:0] EXP_MAX = EXP_MAX_DEF,
  parameter logic [EXP_W-1:0] EXP_RST = EXP_RST_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Exp_increase,
  input  logic             Exp_decrease,
  output logic [EXP_W-1:0] Value
);

  logic             inc_prev_q;
  logic             dec_prev_q;
  logic             inc_rise;
  logic             dec_rise;
  logic [EXP_W-1:0] value_q;
  logic [EXP_W-1:0] value_d;

  always_comb begin
    inc_rise = Exp_increase & ~inc_prev_q;
    dec_rise = Exp_decrease & ~dec_prev_q;
    value_d  = value_q;
    // Bounds checked first so the register never wraps.
    if (Enable && inc_rise && !dec_rise && value_q < EXP_MAX) begin
      value_d = value_q + EXP_W'(1);
    end else if (Enable && dec_rise && !inc_rise &&
                 value_q > EXP_MIN) begin
      value_d = value_q - EXP_W'(1);
    end
  end

  // Previous-value flops track the buttons even while disabled,
  // so a press held through a capture does not fire afterwards.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      inc_prev_q <= 1'b0;
      dec_prev_q <= 1'b0;
      value_q    <= EXP_RST;
    end else begin
      inc_prev_q <= Exp_increase;
      dec_prev_q <= Exp_decrease;
      value_q    <= value_d;
    end
  end

  assign Value = value_q;

endmodule

// File: rtl/camera_ctrl.sv
// Capture sequencer: erase release, timed exposure, two-row readout.
// In: Clk, Reset, Init, Exp_increase/decrease, Ovf5. Out: Start,
// Initial[4:0], Erase, Expose, NRE_1, NRE_2, ADC, Busy.
module camera_ctrl
  import camera_pkg::*;
#(
  parameter logic [EXP_W-1:0] EXP_MIN = EXP_MIN_DEF,
  parameter logic [EXP_W-1:0] EXP_MAX = EXP_MAX_DEF,
  parameter logic [EXP_W-1:0] EXP_RST = EXP_RST_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Init,
  input  logic             Exp_increase,
  input  logic             Exp_decrease,
  input  logic             Ovf5,
  output logic             Start,
  output logic [EXP_W-1:0] Initial,
  output logic             Erase,
  output logic             Expose,
  output logic             NRE_1,
  output logic             NRE_2,
  output logic             ADC,
  output logic             Busy
);

  state_e              state_q;
  logic [STEP_W-1:0]   step_q;
  logic [STEP_W-1:0]   step_nx;
  rd_t                 rd_q;
  rd_t                 rd_nx;
  logic                start_q;
  logic                erase_q;
  logic                expose_q;
  logic                busy_q;
  logic                adj_en;

  // Init wins over a same-cycle button edge.
  assign adj_en = (state_q == IDLE) && !Init;

  exposure_adjust #(
    .EXP_MIN(EXP_MIN),
    .EXP_MAX(EXP_MAX),
    .EXP_RST(EXP_RST)
  ) u_adj (
    .Clk         (Clk),
    .Reset       (Reset),
    .Enable      (adj_en),
    .Exp_increase(Exp_increase),
    .Exp_decrease(Exp_decrease),
    .Value       (Initial)
  );

  // Outputs are registered with the decode of the step being entered.
  always_comb begin
    step_nx = step_q + STEP_W'(1);
    rd_nx   = rd_decode(step_nx);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      step_q   <= '0;
      rd_q     <= '{nre1: 1'b1, nre2: 1'b1, adc: 1'b0};
      start_q  <= 1'b0;
      erase_q  <= 1'b1;
      expose_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (Init) begin
            state_q  <= EXPOSURE;
            start_q  <= 1'b1;
            erase_q  <= 1'b0;
            expose_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        EXPOSURE: begin
          start_q <= 1'b0;
          if (Ovf5) begin
            state_q  <= READOUT;
            step_q   <= '0;
            expose_q <= 1'b0;
            rd_q     <= rd_decode('0);
          end
        end
        READOUT: begin
          if (step_q == STEP_LAST) begin
            state_q <= IDLE;
            step_q  <= '0;
            rd_q    <= '{nre1: 1'b1, nre2: 1'b1, adc: 1'b0};
            erase_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            step_q <= step_nx;
            rd_q   <= rd_nx;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Start  = start_q;
  assign Erase  = erase_q;
  assign Expose = expose_q;
  assign NRE_1  = rd_q.nre1;
  assign NRE_2  = rd_q.nre2;
  assign ADC    = rd_q.adc;
  assign Busy   = busy_q;

endmodule
